// File: rtl/spsram_port_ctrl.sv
// spsram_port_ctrl: valid/ready front-end for a registered-output single-port SRAM,
// with in-order read responses buffered in a credit-protected FIFO.
module spsram_port_ctrl #(
  parameter int W         = 32,
  parameter int N         = 128,
  parameter int RSP_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_vld,
  input  logic                 req_wen,
  input  logic [$clog2(N)-1:0] req_addr,
  input  logic [W-1:0]         req_din,
  output logic                 req_rdy,
  output logic                 rsp_vld,
  output logic [W-1:0]         rsp_dat,
  input  logic                 rsp_rdy,
  output logic                 mem_en,
  output logic                 mem_wen,
  output logic [$clog2(N)-1:0] mem_addr,
  output logic [W-1:0]         mem_din,
  input  logic [W-1:0]         mem_dout
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(RSP_DEPTH - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_occ;
  logic          r_rd_pend;
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [W-1:0]  r_fifo [RSP_DEPTH];
  logic          w_acc;
  logic          w_rd;
  logic          w_pop;

  // cnt reserves a slot for every in-flight read, so req_rdy alone prevents overflow
  assign req_rdy  = r_cnt < DEPTH_C;
  assign w_acc    = req_vld & req_rdy;
  assign w_rd     = w_acc & ~req_wen;
  assign w_pop    = rsp_vld & rsp_rdy;
  assign mem_en   = w_acc;
  assign mem_wen  = req_wen;
  assign mem_addr = req_addr;
  assign mem_din  = req_din;
  assign rsp_vld  = r_occ != '0;
  assign rsp_dat  = r_fifo[r_rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_occ     <= '0;
      r_rd_pend <= 1'b0;
      r_wp      <= '0;
      r_rp      <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      r_rd_pend <= w_rd;
      r_cnt     <= r_cnt + CW'(w_rd) - CW'(w_pop);
      r_occ     <= r_occ + CW'(r_rd_pend) - CW'(w_pop);
      if (r_rd_pend) begin
        r_fifo[r_wp] <= mem_dout;
        r_wp         <= r_wp == LAST_P ? '0 : r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp == LAST_P ? '0 : r_rp + 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(r_rd_pend && r_occ == DEPTH_C && !w_pop));
  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) r_cnt <= DEPTH_C);
endmodule

// File: tb/tb_spsram_port_ctrl.sv
// tb_spsram_port_ctrl: directed and random checks of spsram_port_ctrl against a
// registered-output SRAM model, with a queue scoreboard for read responses.
module tb_spsram_port_ctrl;
  localparam int W  = 32;
  localparam int N  = 128;
  localparam int D  = 4;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_vld = 1'b0;
  logic          req_wen = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [W-1:0]  req_din = '0;
  logic          req_rdy;
  logic          rsp_vld;
  logic [W-1:0]  rsp_dat;
  logic          rsp_rdy = 1'b1;
  logic          mem_en;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_din;
  logic [W-1:0]  mem_dout = '0;

  spsram_port_ctrl #(.W(W), .N(N), .RSP_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_wen(req_wen), .req_addr(req_addr),
    .req_din(req_din), .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_dat(rsp_dat),
    .rsp_rdy(rsp_rdy), .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  logic [W-1:0] sram [N];
  logic [W-1:0] ref_mem [N];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen) sram[mem_addr] <= mem_din;
      else mem_dout <= sram[mem_addr];
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  int pop_cyc[$];
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_vld && rsp_rdy) begin
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got %h expected no response", rsp_dat);
      end else check("rsp_dat", rsp_dat, exp_q.pop_front());
    end
  end

  task automatic issue(input logic wen, input logic [AW-1:0] a, input logic [W-1:0] d,
                       input logic [W-1:0] e, output int tries, output int acc_cyc);
    logic acc;
    acc = 1'b0;
    tries = 0;
    acc_cyc = -1;
    req_vld = 1'b1; req_wen = wen; req_addr = a; req_din = d;
    while (!acc && tries < 200) begin
      @(negedge clk);
      tries++;
      if (req_rdy) begin
        acc = 1'b1;
        acc_cyc = cyc;
        if (wen) ref_mem[a] = d;
        else exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    req_vld = 1'b0;
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_timeout: got no accept expected accept addr %0d", a);
    end
  endtask

  task automatic offer_rd(input logic [AW-1:0] a, input logic [W-1:0] e, output logic acc);
    req_vld = 1'b1; req_wen = 1'b0; req_addr = a; req_din = '0;
    @(negedge clk);
    acc = req_rdy;
    if (acc) exp_q.push_back(e);
    @(posedge clk); #1;
    req_vld = 1'b0;
  endtask

  task automatic wait_vld(output int c);
    int n;
    n = 0;
    c = -1;
    while (n < 50) begin
      @(negedge clk);
      if (rsp_vld) begin
        c = cyc;
        n = 50;
      end
      n++;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rsp_rdy = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int t, c, c0, vc, nacc, maxq;
    logic acc;
    for (int i = 0; i < N; i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end
    @(negedge clk);
    check("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_req_rdy", 32'(req_rdy), 32'd1);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // T1: write then read, 2-cycle latency
    issue(1'b1, 7'd5, 32'hDEADBEEF, '0, t, c);
    issue(1'b0, 7'd5, '0, 32'hDEADBEEF, t, c);
    wait_vld(vc);
    check("t1_latency", 32'(vc - c), 32'd2);
    drain();

    // T2: 8 back-to-back reads with rsp_rdy held high
    for (int a = 0; a < 8; a++) issue(1'b1, 7'(a), 32'h100 + 32'(a), '0, t, c);
    pop_cyc.delete();
    for (int a = 0; a < 8; a++) begin
      issue(1'b0, 7'(a), '0, 32'h100 + 32'(a), t, c);
      if (a == 0) c0 = c;
      check("t2_one_try", 32'(t), 32'd1);
    end
    drain();
    check("t2_pop_count", 32'(pop_cyc.size()), 32'd8);
    if (pop_cyc.size() == 8) begin
      check("t2_first_lat", 32'(pop_cyc[0] - c0), 32'd2);
      for (int i = 1; i < 8; i++) check("t2_back_to_back", 32'(pop_cyc[i] - pop_cyc[0]), 32'(i));
    end

    // T3: credit exhaustion with rsp_rdy low
    rsp_rdy = 1'b0;
    nacc = 0;
    for (int a = 0; a < 6; a++) begin
      offer_rd(7'(a), 32'h100 + 32'(a), acc);
      if (acc) nacc++;
    end
    check("t3_accepted", 32'(nacc), 32'd4);
    @(negedge clk);
    check("t3_rdy_low", 32'(req_rdy), 32'd0);
    check("t3_hold_vld", 32'(rsp_vld), 32'd1);
    check("t3_hold_dat", rsp_dat, 32'h100);
    @(posedge clk); #1;
    rsp_rdy = 1'b1;
    @(negedge clk);
    check("t3_rdy_before_pop", 32'(req_rdy), 32'd0);
    @(negedge clk);
    check("t3_rdy_after_pop", 32'(req_rdy), 32'd1);
    @(posedge clk); #1;
    drain();

    // T4: top address, overwrite ordering
    issue(1'b1, 7'd127, 32'hA5A5A5A5, '0, t, c);
    issue(1'b0, 7'd127, '0, 32'hA5A5A5A5, t, c);
    issue(1'b1, 7'd127, 32'h0, '0, t, c);
    issue(1'b0, 7'd127, '0, 32'h0, t, c);
    drain();

    // T5: reset with two buffered responses and one read in flight
    rsp_rdy = 1'b0;
    for (int a = 0; a < 3; a++) issue(1'b0, 7'(a), '0, 32'h100 + 32'(a), t, c);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("t5_rst_vld", 32'(rsp_vld), 32'd0);
    check("t5_rst_rdy", 32'(req_rdy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_rdy = 1'b1;
    nacc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_vld) nacc++;
    end
    check("t5_no_stale", 32'(nacc), 32'd0);
    @(posedge clk); #1;

    // T6: random traffic against the reference memory
    maxq = 0;
    for (int i = 0; i < 10000; i++) begin
      req_vld  = 1'($urandom_range(0, 1));
      req_wen  = 1'($urandom_range(0, 1));
      req_addr = 7'($urandom_range(0, 15)) | (($urandom_range(0, 7) == 0) ? 7'h70 : 7'h0);
      req_din  = $urandom;
      rsp_rdy  = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (req_vld && req_rdy) begin
        if (req_wen) ref_mem[req_addr] = req_din;
        else exp_q.push_back(ref_mem[req_addr]);
      end
      if (exp_q.size() > maxq) maxq = exp_q.size();
      @(posedge clk); #1;
    end
    req_vld = 1'b0;
    drain();
    check("t6_credit_bound", 32'(maxq <= D), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
